// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush, memory-wait hold with timeout
//
// Purpose
//   Generates hold/bubble/flush controls for a 5-stage pipeline.
//   Priority: ERROR > memory wait > taken branch > load-use.
//   A memory wait longer than WAIT_TIMEOUT consecutive cycles locks the block in
//   ERROR (all stages held, err set) until rst_n is asserted.
//
// Parameters
//   WAIT_TIMEOUT  max consecutive memory-wait cycles tolerated (1..255)
//
// Optional feature
//   PIPE_HAZARD_STALL_CNT_EN  when defined, stall_count counts clocks with hold_if_pc
//                             high (saturating); otherwise stall_count is tied to 0.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_rs, id_rt, id_uses_rt        source registers of the ID instruction
//   ex_memread, ex_rt               load in EX and its destination register
//   mem_access, mem_ready           data-memory access in MEM and its completion
//   branch_taken                    branch/jump resolved taken in EX
//   hold_if_pc .. hold_mem_wb       pipeline register holds (1 = keep contents)
//   bubble_id_ex, flush_if_id       insert NOP into ID/EX, squash IF/ID
//   err, state, stall_count         sticky timeout flag, FSM state, stall counter

module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        mem_access,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        hold_if_pc,
  output logic        hold_id_ex,
  output logic        hold_ex_mem,
  output logic        hold_mem_wb,
  output logic        bubble_id_ex,
  output logic        flush_if_id,
  output logic        err,
  output logic [1:0]  state,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT = 8'(WAIT_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;

  logic memwait;
  logic loaduse;
  logic hold_all_c;
  logic hold_pc_c;
  logic bubble_c;
  logic flush_c;

  assign memwait = mem_access & ~mem_ready;
  assign loaduse = ex_memread & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    hold_all_c = 1'b0;
    hold_pc_c  = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;

    // Output decode. The illegal encoding decodes like RUN for its one cycle.
    if (state_q == ST_ERROR) begin
      hold_all_c = 1'b1;
    end else if (memwait) begin
      // The EX instruction is frozen, so branch/load-use are re-evaluated after release.
      hold_all_c = 1'b1;
    end else if (branch_taken) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
    end else if (loaduse) begin
      hold_pc_c = 1'b1;
      bubble_c  = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (memwait) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          wait_cnt_d = 8'd0;
        end
      end
      ST_MEM_WAIT: begin
        if (memwait) begin
          // wait_cnt_q counts wait cycles already completed; one more past the limit trips.
          if (wait_cnt_q == TIMEOUT) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Outputs are gated by rst_n so they clear the instant reset asserts, even
  // while the hazard inputs are still active.
  assign hold_if_pc   = rst_n & (hold_all_c | hold_pc_c);
  assign hold_id_ex   = rst_n & hold_all_c;
  assign hold_ex_mem  = rst_n & hold_all_c;
  assign hold_mem_wb  = rst_n & hold_all_c;
  assign bubble_id_ex = rst_n & bubble_c;
  assign flush_if_id  = rst_n & flush_c;
  assign err          = err_q;
  assign state        = state_q;

`ifdef PIPE_HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else if (hold_if_pc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl (WAIT_TIMEOUT=4)

module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  id_rs = 5'd0;
  logic [4:0]  id_rt = 5'd0;
  logic        id_uses_rt = 1'b0;
  logic        ex_memread = 1'b0;
  logic [4:0]  ex_rt = 5'd0;
  logic        mem_access = 1'b0;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        hold_if_pc, hold_id_ex, hold_ex_mem, hold_mem_wb;
  logic        bubble_id_ex, flush_if_id, err;
  logic [1:0]  state;
  logic [31:0] stall_count;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_stall = 32'd0;

  pipe_hazard_ctrl #(.WAIT_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .mem_access   (mem_access),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .hold_if_pc   (hold_if_pc),
    .hold_id_ex   (hold_id_ex),
    .hold_ex_mem  (hold_ex_mem),
    .hold_mem_wb  (hold_mem_wb),
    .bubble_id_ex (bubble_id_ex),
    .flush_if_id  (flush_if_id),
    .err          (err),
    .state        (state),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected vector order: {hold_if_pc, hold_id_ex, hold_ex_mem, hold_mem_wb, bubble_id_ex, flush_if_id}
  task automatic chk_outs(input string tag, input logic [5:0] exp);
    check(tag, {26'd0, hold_if_pc, hold_id_ex, hold_ex_mem, hold_mem_wb, bubble_id_ex, flush_if_id},
          {26'd0, exp});
  endtask

  task automatic chk_stall(input string tag);
`ifdef PIPE_HAZARD_STALL_CNT_EN
    check(tag, stall_count, exp_stall);
`else
    check(tag, stall_count, 32'd0);
`endif
  endtask

  // Advance one clock; h is the hold_if_pc value expected during the cycle just ending.
  task automatic tick(input bit h);
    if (h && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk_outs("reset_outs", 6'b000000);
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    chk_stall("reset_stall");
    @(posedge clk); #1;
    rst_n = 1'b1; #1;

    // Load-use via rs, then no stall when the load targets r0
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #1;
    chk_outs("loaduse_rs", 6'b100010);
    tick(1'b1);
    check("loaduse_state", {30'd0, state}, 32'd0);
    ex_rt = 5'd0; id_rs = 5'd0; #1;
    chk_outs("loaduse_r0", 6'b000000);

    // rt match only counts when the ID instruction reads rt
    ex_rt = 5'd5; id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 1'b0; #1;
    chk_outs("rt_unused", 6'b000000);
    id_uses_rt = 1'b1; #1;
    chk_outs("loaduse_rt", 6'b100010);

    // Branch beats load-use
    branch_taken = 1'b1; #1;
    chk_outs("branch_lu", 6'b000011);
    tick(1'b0);
    chk_stall("stall_a");
    branch_taken = 1'b0; ex_memread = 1'b0; id_uses_rt = 1'b0; #1;
    chk_outs("idle", 6'b000000);

    // Memory wait of 3 cycles with branch and load-use also present
    mem_access = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1; ex_memread = 1'b1; #1;
    chk_outs("mw_c1", 6'b111100);
    check("mw_c1_state", {30'd0, state}, 32'd0);
    tick(1'b1);
    chk_outs("mw_c2", 6'b111100);
    check("mw_c2_state", {30'd0, state}, 32'd1);
    tick(1'b1);
    chk_outs("mw_c3", 6'b111100);
    check("mw_c3_state", {30'd0, state}, 32'd1);
    tick(1'b1);
    mem_ready = 1'b1; branch_taken = 1'b0; ex_memread = 1'b0; #1;
    chk_outs("mw_release", 6'b000000);
    check("mw_release_state", {30'd0, state}, 32'd1);
    tick(1'b0);
    check("mw_done_state", {30'd0, state}, 32'd0);
    check("mw_done_err", {31'd0, err}, 32'd0);
    chk_stall("stall_b");

    // Wait of exactly WAIT_TIMEOUT cycles then completes: no error
    mem_ready = 1'b0; #1;
    repeat (4) tick(1'b1);
    mem_ready = 1'b1; #1;
    chk_outs("exact_release", 6'b000000);
    check("exact_state", {30'd0, state}, 32'd1);
    tick(1'b0);
    check("exact_done_state", {30'd0, state}, 32'd0);
    check("exact_err", {31'd0, err}, 32'd0);

    // Timeout: 5th consecutive wait cycle enters ERROR
    mem_ready = 1'b0; #1;
    repeat (4) tick(1'b1);
    check("to_pre_state", {30'd0, state}, 32'd1);
    check("to_pre_err", {31'd0, err}, 32'd0);
    tick(1'b1);
    check("to_state", {30'd0, state}, 32'd2);
    check("to_err", {31'd0, err}, 32'd1);
    mem_access = 1'b0; #1;
    chk_outs("err_hold", 6'b111100);
    branch_taken = 1'b1; ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #1;
    chk_outs("err_prio", 6'b111100);
    tick(1'b1);
    tick(1'b1);
    check("err_sticky_state", {30'd0, state}, 32'd2);
    check("err_sticky", {31'd0, err}, 32'd1);
    chk_stall("stall_c");

    // Asynchronous reset in ERROR, no clock edge involved
    #2 rst_n = 1'b0; exp_stall = 32'd0; #1;
    chk_outs("arst_err_outs", 6'b000000);
    check("arst_err_state", {30'd0, state}, 32'd0);
    check("arst_err_err", {31'd0, err}, 32'd0);
    chk_stall("arst_err_stall");
    @(posedge clk); #1;
    rst_n = 1'b1; branch_taken = 1'b0; ex_memread = 1'b0;
    mem_access = 1'b1; mem_ready = 1'b0; #1;
    chk_outs("rel_mw_outs", 6'b111100);
    check("rel_mw_state", {30'd0, state}, 32'd0);
    tick(1'b1);
    tick(1'b1);
    check("mid_mw_state", {30'd0, state}, 32'd1);

    // Asynchronous reset mid-MEM_WAIT while the wait inputs stay active
    #2 rst_n = 1'b0; exp_stall = 32'd0; #1;
    chk_outs("arst_mw_outs", 6'b000000);
    check("arst_mw_state", {30'd0, state}, 32'd0);
    chk_stall("arst_mw_stall");
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    check("rel_run_state", {30'd0, state}, 32'd0);
    chk_outs("rel_run_outs", 6'b111100);
    tick(1'b1);
    check("rel_first_edge", {30'd0, state}, 32'd1);
    mem_ready = 1'b1; #1;
    tick(1'b0);
    check("final_state", {30'd0, state}, 32'd0);
    check("final_err", {31'd0, err}, 32'd0);
    mem_access = 1'b0; #1;
    tick(1'b0);
    chk_stall("stall_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
